sec_location_decoder_24b: RTL and testbench



---
 rtl/sec_loc_pkg.sv | 23 ++
 rtl/gf32_mulx.sv | 16 +
 rtl/sec_location_decoder_24b.sv | 93 +++++++++
 tb/tb_sec_location_decoder_24b.sv | 154 +++++++++++++++
 4 files changed

// File: rtl/sec_loc_pkg.sv
// Shared constants and types for the SEC error-location decoder.
//   W_BITS   : syndrome width / GF(2^32) degree
//   N_BITS   : location output width (24-bit position + sentinel bit)
//   LOC_BITS : number of position bits searched
//   POLY     : low-order terms of x^32+x^22+x^2+x+1
//   NO_ERR   : location reported when W is zero or never matches
package sec_loc_pkg;

  localparam int W_BITS   = 32;
  localparam int N_BITS   = 25;
  localparam int LOC_BITS = 24;

  localparam logic [W_BITS-1:0]   POLY     = 32'h0040_0007;
  localparam logic [N_BITS-1:0]   NO_ERR   = 25'h100_0000;
  localparam logic [LOC_BITS-1:0] LAST_POS = 24'hFF_FFFF;

  typedef enum logic [1:0] {
    START  = 2'd0,
    SEARCH = 2'd1,
    DONE   = 2'd2
  } state_t;

endpackage

// File: rtl/gf32_mulx.sv
// Combinational multiply-by-alpha in GF(2^32).
//   s_in  : field element
//   s_out : s_in * alpha, reduced by the primitive polynomial
// Kept as its own module so several steps can be chained for
// multi-position-per-cycle search variants.
module gf32_mulx
  import sec_loc_pkg::*;
(
  input  logic [W_BITS-1:0] s_in,
  output logic [W_BITS-1:0] s_out
);

  // Shifting out x^31 produces x^32, which folds back as POLY.
  assign s_out = {s_in[W_BITS-2:0], 1'b0} ^ (s_in[W_BITS-1] ? POLY : '0);

endmodule

// File: rtl/sec_location_decoder_24b.sv
// Clocked SEC error-location decoder. Walks alpha^n for n = 0..2^24-1,
// one position per clock, until alpha^n equals the latched syndrome.
//   clk   : rising-edge clock
//   rst_n : asynchronous active-low reset
//   W     : 32-bit syndrome, sampled every edge; any change restarts
//   found : search finished, N valid while high
//   N     : error position, or NO_ERR (bit 24 set) for zero / no match
module sec_location_decoder_24b
  import sec_loc_pkg::*;
(
  input  logic                clk,
  input  logic                rst_n,
  input  logic [W_BITS-1:0]   W,
  output logic                found,
  output logic [N_BITS-1:0]   N
);

  state_t              state_reg, state_next;
  logic [W_BITS-1:0]   w_reg, w_next;
  logic [W_BITS-1:0]   s_reg, s_next;
  logic [LOC_BITS-1:0] cnt_reg, cnt_next;
  logic                found_reg, found_next;
  logic [N_BITS-1:0]   n_reg, n_next;
  logic [W_BITS-1:0]   s_step;
  logic                restart;

  gf32_mulx u_mulx (
    .s_in  (s_reg),
    .s_out (s_step)
  );

  // A new syndrome wins over everything, including a match on this edge,
  // so found never stays high for a value that is no longer presented.
  assign restart = (state_reg == START) || (W != w_reg);

  always_comb begin
    state_next = state_reg;
    w_next     = w_reg;
    s_next     = s_reg;
    cnt_next   = cnt_reg;
    found_next = found_reg;
    n_next     = n_reg;

    if (restart) begin
      w_next     = W;
      s_next     = {{(W_BITS-1){1'b0}}, 1'b1};
      cnt_next   = '0;
      found_next = 1'b0;
      n_next     = '0;
      state_next = SEARCH;
    end else if (state_reg == SEARCH) begin
      if (w_reg == '0) begin
        found_next = 1'b1;
        n_next     = NO_ERR;
        state_next = DONE;
      end else if (s_reg == w_reg) begin
        found_next = 1'b1;
        n_next     = {1'b0, cnt_reg};
        state_next = DONE;
      end else if (cnt_reg == LAST_POS) begin
        // Terminal check precedes the increment, so cnt never wraps.
        found_next = 1'b1;
        n_next     = NO_ERR;
        state_next = DONE;
      end else begin
        s_next   = s_step;
        cnt_next = cnt_reg + 24'd1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg <= START;
      w_reg     <= '0;
      s_reg     <= '0;
      cnt_reg   <= '0;
      found_reg <= 1'b0;
      n_reg     <= '0;
    end else begin
      state_reg <= state_next;
      w_reg     <= w_next;
      s_reg     <= s_next;
      cnt_reg   <= cnt_next;
      found_reg <= found_next;
      n_reg     <= n_next;
    end
  end

  assign found = found_reg;
  assign N     = n_reg;

endmodule

// File: tb/tb_sec_location_decoder_24b.sv
// Directed bench for sec_location_decoder_24b: a scoreboard queue holds
// expected location and latency for each syndrome driven.
module tb_sec_location_decoder_24b;

  logic        clk;
  logic        rst_n;
  logic [31:0] W;
  logic        found;
  logic [24:0] N;

  int tests  = 0;
  int failed = 0;

  localparam logic [24:0] NO_ERR_TB = 25'h100_0000;
  localparam int BUDGET = 300;

  typedef struct {
    logic [24:0] n;
    int          lat;
    string       tag;
  } exp_t;

  exp_t sb[$];

  sec_location_decoder_24b dut (
    .clk   (clk),
    .rst_n (rst_n),
    .W     (W),
    .found (found),
    .N     (N)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference: alpha^n by repeated multiplication modulo x^32+x^22+x^2+x+1.
  function automatic logic [31:0] alpha_pow(input int n);
    logic [31:0] s;
    s = 32'h1;
    for (int i = 0; i < n; i++) begin
      if (s[31]) s = (s << 1) ^ 32'h0040_0007;
      else       s = s << 1;
    end
    return s;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      failed++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Drive a syndrome between edges and queue what the DUT must report.
  task automatic drive(input logic [31:0] w, input logic [24:0] n,
                       input int lat, input string tag);
    exp_t e;
    @(negedge clk);
    W = w;
    e.n = n; e.lat = lat; e.tag = tag;
    sb.push_back(e);
  endtask

  // Count edges until found, then compare against the queued expectation.
  task automatic wait_result();
    exp_t e;
    int   k;
    logic [24:0] n_seen;
    e = sb.pop_front();
    k = 0;
    do begin
      @(posedge clk); #1;
      k++;
      if (k == 1) chk({e.tag, "_drop"}, {31'd0, found}, 32'd0);
    end while (!found && k < BUDGET);
    chk({e.tag, "_found"}, {31'd0, found}, 32'd1);
    chk({e.tag, "_lat"}, k, e.lat);
    chk({e.tag, "_N"}, {7'd0, N}, {7'd0, e.n});
    n_seen = N;
    repeat (3) @(posedge clk);
    #1;
    chk({e.tag, "_hold"}, {6'd0, found, N}, {6'd0, 1'b1, n_seen});
    $display("[TB] %s: W=%08h N=%0d latency=%0d", e.tag, W, N, k);
  endtask

  initial begin
    rst_n = 1'b0;
    W     = 32'h1;
    repeat (2) @(posedge clk);
    #1;
    chk("reset_found", {31'd0, found}, 32'd0);
    chk("reset_N", {7'd0, N}, 32'd0);

    // Release reset with W=1 already present: START forces a load.
    @(negedge clk);
    rst_n = 1'b1;
    sb.push_back('{n: 25'd0, lat: 2, tag: "w1"});
    wait_result();

    drive(32'h2, 25'd1, 3, "w2");                wait_result();
    drive(32'h0040_0007, 25'd32, 34, "alpha32"); wait_result();
    drive(32'h0, NO_ERR_TB, 2, "zero");          wait_result();

    // Back-to-back 1, alpha^5, 1.
    drive(32'h1, 25'd0, 2, "bb_1a");             wait_result();
    drive(alpha_pow(5), 25'd5, 7, "bb_a5");      wait_result();
    drive(32'h1, 25'd0, 2, "bb_1b");             wait_result();

    // Abort mid-search: alpha^40 replaced by alpha^3 before it is found.
    @(negedge clk);
    W = alpha_pow(40);
    repeat (6) @(posedge clk);
    #1;
    chk("abort_busy", {31'd0, found}, 32'd0);
    drive(alpha_pow(3), 25'd3, 5, "abort_new");  wait_result();

    // Reset while results are held: clears outputs without a clock edge.
    @(negedge clk);
    W = alpha_pow(50);
    #2;
    rst_n = 1'b0;
    #1;
    chk("rst_done_found", {31'd0, found}, 32'd0);
    chk("rst_done_N", {7'd0, N}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (10) @(posedge clk);

    // Reset mid-search, then the same W is searched again from START.
    @(negedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    chk("rst_mid_found", {31'd0, found}, 32'd0);
    chk("rst_mid_N", {7'd0, N}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    sb.push_back('{n: 25'd50, lat: 52, tag: "rst_research"});
    wait_result();

    chk("sb_empty", sb.size(), 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

  initial begin
    #2000000;
    $display("[TB] FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

endmodule
